control: RTL
============

// Module: control
// PURPOSE
//   FSM that sequences the expression-solver datapath ("operative") to compute
//   result = A*X^2 + B*X + C in Horner form: ((A*X)+B)*X + C.
//   Drives the load enables, ALU op and mux selects; consumes zero/overflow.
//   Issues a start/done handshake to the top level and holds sticky status flags.
// PARAMETERS
//   H_ADD         1'b0  ALU op code on H for addition.
//   H_MUL         1'b1  ALU op code on H for multiplication.
//   ABORT_ON_OVF  0     1: jump to DONE on the first overflow; 0: finish the sequence.
// PORTS
//   clk       in   1  system clock, rising edge.
//   rst       in   1  asynchronous, active-low reset.
//   start     in   1  level request; sampled only in IDLE.
//   zero      in   1  datapath flag: Reg_H == 0.
//   overflow  in   1  datapath ALU overflow for the current operation (combinational).
//   LX        out  1  load Reg_X from input_X.
//   LS        out  1  load Reg_S from the ALU output.
//   LH        out  1  load Reg_H from the ALU output.
//   H         out  1  ALU op select (H_ADD / H_MUL).
//   M0        out  2  mux0 select: 00 = 0, 01 = A, 10 = B, 11 = C.
//   M1        out  2  mux1 select: 00 = M0_out, 01 = Reg_X, 10 = Reg_S, 11 = Reg_H.
//   M2        out  2  mux2 select: 00 = Reg_X, 01 = M0_out, 10 = Reg_S, 11 = Reg_H.
//   busy      out  1  high in every state except IDLE.
//   done      out  1  one-cycle pulse in DONE.
//   ovf_flag  out  1  sticky: an overflow occurred during the current or last run.
//   zero_flag out  1  registered copy of zero, captured in DONE.
// BEHAVIOUR
//   Reset (rst = 0, asynchronous): state = IDLE; all outputs 0; both flags cleared.
//   Control outputs are Moore-decoded from state. Unlisted outputs are 0; unused selects are 00.
//   States and per-state outputs:
//     IDLE : start = 1 -> LOAD and clear ovf_flag/zero_flag; otherwise stay.
//     LOAD : LX = 1 -> MUL1.
//     MUL1 : H = H_MUL, M0 = 01, M1 = 01, M2 = 01, LS = 1   (S = A*X)   -> ADD1.
//     ADD1 : H = H_ADD, M0 = 10, M1 = 00, M2 = 10, LS = 1   (S = S+B)   -> MUL2.
//     MUL2 : H = H_MUL, M1 = 01, M2 = 10, LS = 1            (S = S*X)   -> ADD2.
//     ADD2 : H = H_ADD, M0 = 11, M1 = 00, M2 = 10, LH = 1   (H = S+C)   -> DONE.
//     DONE : done = 1; zero_flag <= zero at the closing edge -> IDLE.
//   Overflow handling:
//     - ovf_flag <= 1 at any edge in MUL1..ADD2 where overflow = 1.
//     - With ABORT_ON_OVF = 1, that same edge goes to DONE instead of the next state.
//     - On abort, LS/LH are still asserted for that cycle (the datapath keeps the wrapped value).
//   Latency: start sampled at edge k -> done is high during cycle k+6.
//     Reg_H is valid from the start of DONE.
//   Handshake:
//     - start is ignored while busy.
//     - If start is still high when the FSM returns to IDLE, a new run begins on the next edge.
//     - Back-to-back runs: one IDLE cycle between done pulses.
//   Flags hold their value after DONE until the next accepted start.
//   Reset mid-run: the FSM aborts immediately to IDLE with no done pulse.
//   Exactly one of LX/LS/LH is asserted per active cycle; none in IDLE/DONE.
// TESTING
//   1. Reset while start = 1 -> all outputs 0, state IDLE; release rst -> LOAD on the next edge.
//   2. A=2, B=3, C=4, X=5, pulse start -> done at cycle k+6, result = 69,
//      zero_flag = 0, ovf_flag = 0.
//   3. A=1, B=0, C=-9, X=3 -> result = 0, zero_flag = 1.
//      A=-1, B=0, C=0, X=4 -> result = -16, zero_flag = 0.
//   4. A=300, X=127, B=C=0, ABORT_ON_OVF = 0 -> ovf_flag = 1 and done still at k+6.
//      Same with ABORT_ON_OVF = 1 -> done at k+3, ovf_flag = 1.
//   5. Hold start high for 3 runs -> done pulses 7 cycles apart;
//      start toggled while busy has no effect on the sequence.
//   6. Assert rst during MUL2 -> IDLE within the same cycle, no done pulse,
//      flags cleared; the next run completes correctly.

Source files
------------

// File: rtl/control.sv
// Sequencer for the expression-solver datapath: evaluates A*X^2 + B*X + C in Horner form
// and drives the handshake and sticky status flags. All control outputs are registered.
module control #(
    parameter logic H_ADD        = 1'b0,
    parameter logic H_MUL        = 1'b1,
    parameter int   ABORT_ON_OVF = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       zero,
    input  logic       overflow,
    output logic       LX,
    output logic       LS,
    output logic       LH,
    output logic       H,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       busy,
    output logic       done,
    output logic       ovf_flag,
    output logic       zero_flag
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL1,
        ADD1,
        MUL2,
        ADD2,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic       ovf_flag_q, ovf_flag_d;
    logic       zero_flag_q, zero_flag_d;
    logic       lx_q, lx_d;
    logic       ls_q, ls_d;
    logic       lh_q, lh_d;
    logic       h_q, h_d;
    logic [1:0] m0_q, m0_d;
    logic [1:0] m1_q, m1_d;
    logic [1:0] m2_q, m2_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Next state and flag updates.
    always_comb begin
        state_d     = state_q;
        ovf_flag_d  = ovf_flag_q;
        zero_flag_d = zero_flag_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    ovf_flag_d  = 1'b0;
                    zero_flag_d = 1'b0;
                end
            end
            LOAD: state_d = MUL1;
            MUL1, ADD1, MUL2, ADD2: begin
                case (state_q)
                    MUL1:    state_d = ADD1;
                    ADD1:    state_d = MUL2;
                    MUL2:    state_d = ADD2;
                    default: state_d = DONE;
                endcase
                if (overflow) begin
                    ovf_flag_d = 1'b1;
                    if (ABORT_ON_OVF != 0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                zero_flag_d = zero;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registers present them
    // during the cycle that state is occupied.
    always_comb begin
        lx_d   = 1'b0;
        ls_d   = 1'b0;
        lh_d   = 1'b0;
        h_d    = 1'b0;
        m0_d   = 2'b00;
        m1_d   = 2'b00;
        m2_d   = 2'b00;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        case (state_d)
            LOAD: lx_d = 1'b1;
            MUL1: begin
                h_d  = H_MUL;
                m0_d = 2'b01;
                m1_d = 2'b01;
                m2_d = 2'b01;
                ls_d = 1'b1;
            end
            ADD1: begin
                h_d  = H_ADD;
                m0_d = 2'b10;
                m1_d = 2'b00;
                m2_d = 2'b10;
                ls_d = 1'b1;
            end
            MUL2: begin
                h_d  = H_MUL;
                m1_d = 2'b01;
                m2_d = 2'b10;
                ls_d = 1'b1;
            end
            ADD2: begin
                h_d  = H_ADD;
                m0_d = 2'b11;
                m1_d = 2'b00;
                m2_d = 2'b10;
                lh_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ovf_flag_q  <= 1'b0;
            zero_flag_q <= 1'b0;
            lx_q        <= 1'b0;
            ls_q        <= 1'b0;
            lh_q        <= 1'b0;
            h_q         <= 1'b0;
            m0_q        <= 2'b00;
            m1_q        <= 2'b00;
            m2_q        <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ovf_flag_q  <= ovf_flag_d;
            zero_flag_q <= zero_flag_d;
            lx_q        <= lx_d;
            ls_q        <= ls_d;
            lh_q        <= lh_d;
            h_q         <= h_d;
            m0_q        <= m0_d;
            m1_q        <= m1_d;
            m2_q        <= m2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign LX        = lx_q;
    assign LS        = ls_q;
    assign LH        = lh_q;
    assign H         = h_q;
    assign M0        = m0_q;
    assign M1        = m1_q;
    assign M2        = m2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf_flag  = ovf_flag_q;
    assign zero_flag = zero_flag_q;

endmodule
